// File: rtl/spi_master_ctrl_pkg.sv
// Shared widths, frame length, inter-frame gap and controller state encoding
// for the SPI register-file initiator.
package spi_pkg;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int unsigned CS_GAP    = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_m_state_t;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Command handshake plus SPI pins of the initiator, bundled for port lists.
// master = the controller, slave = the host/link side that faces it.
interface spi_master_ctrl_if #(
  parameter int unsigned ADDR_W = spi_pkg::ADDR_W,
  parameter int unsigned DATA_W = spi_pkg::DATA_W
);

  logic              start;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, wr, addr, wdata, miso,
    output busy, done, rd_data, sclk, cs_n, mosi
  );

  modport slave (
    output start, wr, addr, wdata, miso,
    input  busy, done, rd_data, sclk, cs_n, mosi
  );

endinterface

// File: rtl/spi_master_ctrl_sclk_gen.sv
// Half-period timer for the initiator: ticks every CLK_DIV cycles while enabled
// and toggles SCLK on ticks when toggling is allowed; idles low when disabled.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic toggle_en_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);
  import spi_pkg::*;

  localparam int unsigned      CNT_W = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  assign tick   = en_i && (cnt_q == LAST);
  // Strobes name the edge SCLK takes at the end of this cycle.
  assign rise_o = tick && toggle_en_i && !sclk_q;
  assign fall_o = tick && toggle_en_i && sclk_q;
  assign tick_o = tick;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      if (toggle_en_i) sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  a_rise_from_low: assert property (@(posedge clk) disable iff (rst) rise_o |-> !sclk_q);
  a_fall_from_high: assert property (@(posedge clk) disable iff (rst) fall_o |-> sclk_q);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: one 20-bit read/write frame per accepted command.
// Optional SPI_MASTER_CS_GAP_EN inserts CS_GAP cycles of cs_n high (busy held) after each frame.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = spi_pkg::ADDR_W,
  parameter int unsigned DATA_W  = spi_pkg::DATA_W
) (
  input logic               clk,
  input logic               rst,
  spi_master_ctrl_if.master bus
);
  import spi_pkg::*;

  localparam int unsigned      FRAME_BITS = 1 + ADDR_W + DATA_W;
  localparam int unsigned      BIT_W      = cnt_width(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_master_ctrl: CLK_DIV must be at least 1");
  end

  spi_m_state_t          state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [DATA_W-1:0]     cap_q, cap_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;

`ifdef SPI_MASTER_CS_GAP_EN
  localparam int unsigned      GAP_W    = cnt_width(CS_GAP);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(CS_GAP - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  logic sclk_en, sclk_toggle;
  logic tick, rise, fall, sclk;

  assign sclk_en     = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign sclk_toggle = (state_q == SETUP) || (state_q == SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (sclk_en),
    .toggle_en_i (sclk_toggle),
    .tick_o      (tick),
    .rise_o      (rise),
    .fall_o      (fall),
    .sclk_o      (sclk)
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    cap_d     = cap_q;
    rd_data_d = rd_data_q;
    bit_d     = bit_q;
    wr_d      = wr_q;
    done_d    = 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
    gap_d     = gap_q;
`endif

    // Only the last DATA_W samples survive, so address-phase MISO falls out.
    if (rise) cap_d = {cap_q[DATA_W-2:0], bus.miso};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          frame_d = {bus.wr, bus.addr, bus.wr ? bus.wdata : {DATA_W{1'b0}}};
          wr_d    = bus.wr;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == LAST_BIT) state_d = HOLD;
          else                   bit_d   = bit_q + BIT_W'(1);
        end
      end
      HOLD: begin
        if (tick) begin
          done_d = 1'b1;
          if (!wr_q) rd_data_d = cap_q;
`ifdef SPI_MASTER_CS_GAP_EN
          state_d = GAP;
          gap_d   = '0;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SPI_MASTER_CS_GAP_EN
      GAP: begin
        if (gap_q == LAST_GAP) state_d = IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      cap_q     <= '0;
      rd_data_q <= '0;
      bit_q     <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      cap_q     <= cap_d;
      rd_data_q <= rd_data_d;
      bit_q     <= bit_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
`ifdef SPI_MASTER_CS_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  // cs_n and busy decode straight from state so an async reset releases them at once.
  assign bus.busy    = (state_q != IDLE);
  assign bus.cs_n    = !sclk_en;
  assign bus.sclk    = sclk;
  assign bus.mosi    = frame_q[FRAME_BITS-1];
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;

  a_done_pulse: assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done);
  a_sclk_idle:  assert property (@(posedge clk) disable iff (rst) bus.cs_n |-> !bus.sclk);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: CLK_DIV=4 frame table plus corner sequences,
// and a CLK_DIV=1 back-to-back read pair; expectations follow SPI_MASTER_CS_GAP_EN.
module tb_spi_master_ctrl;

  localparam int DONE4 = 1 + 41 * 4;
  localparam int RISE4 = 1 + 4;

`ifdef SPI_MASTER_CS_GAP_EN
  localparam int  EXP_CS_HIGH   = 5;
  localparam logic EXP_BUSY_DONE = 1'b1;
`else
  localparam int  EXP_CS_HIGH   = 1;
  localparam logic EXP_BUSY_DONE = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  sval;
    logic [19:0] exp_mosi;
    logic [7:0]  exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_master_ctrl_if #(.ADDR_W(11), .DATA_W(8)) bus4 ();
  spi_master_ctrl_if #(.ADDR_W(11), .DATA_W(8)) bus1 ();

  spi_master_ctrl #(.CLK_DIV(4), .ADDR_W(11), .DATA_W(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  spi_master_ctrl #(.CLK_DIV(1), .ADDR_W(11), .DATA_W(8)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Mode-0 slave models: MISO changes after SCLK falls, MOSI recorded at SCLK rise.
  logic [7:0]  sdata4, sdata1;
  logic [19:0] tx4, rx4, tx1, rx1;
  logic        cs4_p, sk4_p, cs1_p, sk1_p;
  int          rise4, rise1;

  always @(negedge clk) begin
    if (rst) begin
      cs4_p = 1'b1; sk4_p = 1'b0; bus4.miso = 1'b0;
    end else begin
      if (cs4_p && !bus4.cs_n) begin
        tx4 = {12'h000, sdata4}; rx4 = '0; rise4 = 0; bus4.miso = tx4[19];
      end else if (!bus4.cs_n) begin
        if (!sk4_p && bus4.sclk) begin rx4 = {rx4[18:0], bus4.mosi}; rise4++; end
        if (sk4_p && !bus4.sclk) begin tx4 = {tx4[18:0], 1'b0}; bus4.miso = tx4[19]; end
      end
      cs4_p = bus4.cs_n; sk4_p = bus4.sclk;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      cs1_p = 1'b1; sk1_p = 1'b0; bus1.miso = 1'b0;
    end else begin
      if (cs1_p && !bus1.cs_n) begin
        tx1 = {12'h000, sdata1}; rx1 = '0; rise1 = 0; bus1.miso = tx1[19];
      end else if (!bus1.cs_n) begin
        if (!sk1_p && bus1.sclk) begin rx1 = {rx1[18:0], bus1.mosi}; rise1++; end
        if (sk1_p && !bus1.sclk) begin tx1 = {tx1[18:0], 1'b0}; bus1.miso = tx1[19]; end
      end
      cs1_p = bus1.cs_n; sk1_p = bus1.sclk;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One CLK_DIV=4 frame; optional stray start pulses at cycles ga/gb (-1 = none).
  task automatic run4(input vec_t v, input int ga, input int gb);
    int          done_cyc, first_rise, ndone, cs_low_after, rises;
    logic        b1, c1, m1;
    logic [19:0] frame;
    logic [7:0]  rd_at_done;
    done_cyc = -1; first_rise = -1; ndone = 0; cs_low_after = 0; rises = -1;
    b1 = 1'b0; c1 = 1'b1; m1 = 1'b0; frame = '0; rd_at_done = '0;
    sdata4 = v.sval;
    @(negedge clk);
    bus4.wr = v.wr; bus4.addr = v.addr; bus4.wdata = v.wdata; bus4.start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      bus4.start = (n == ga) || (n == gb);
      if (bus4.start) begin
        bus4.wr = ~v.wr; bus4.addr = ~v.addr; bus4.wdata = ~v.wdata;
      end
      if (n == 1) begin b1 = bus4.busy; c1 = bus4.cs_n; m1 = bus4.mosi; end
      if (first_rise < 0 && bus4.sclk) first_rise = n;
      if (bus4.done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = n; rd_at_done = bus4.rd_data; frame = rx4; rises = rise4;
        end
      end
      if (done_cyc >= 0 && n > done_cyc && !bus4.cs_n) cs_low_after++;
    end
    bus4.start = 1'b0;
    chk("busy_c1", b1, 1);
    chk("csn_c1", c1, 0);
    chk("mosi_c1", m1, v.exp_mosi[19]);
    chk("first_rise", first_rise, RISE4);
    chk("done_cycle", done_cyc, DONE4);
    chk("done_count", ndone, 1);
    chk("mosi_frame", frame, v.exp_mosi);
    chk("rise_count", rises, 20);
    chk("rd_data", rd_at_done, v.exp_rd);
    chk("csn_after", cs_low_after, 0);
  endtask

  vec_t vecs[7];
  int   nd, d1, gap, m;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus4.start = 1'b0; bus4.wr = 1'b0; bus4.addr = '0; bus4.wdata = '0;
    bus1.start = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    sdata4 = '0; sdata1 = '0;

    vecs[0] = '{1'b1, 11'h123, 8'h5A, 8'h00, 20'h9235A, 8'h00};
    vecs[1] = '{1'b0, 11'h7FF, 8'h00, 8'hA5, 20'h7FF00, 8'hA5};
    vecs[2] = '{1'b1, 11'h7FF, 8'hFF, 8'h33, 20'hFFFFF, 8'hA5};
    vecs[3] = '{1'b0, 11'h000, 8'h00, 8'h81, 20'h00000, 8'h81};
    vecs[4] = '{1'b1, 11'h400, 8'h01, 8'hFF, 20'hC0001, 8'h81};
    vecs[5] = '{1'b1, 11'h2B5, 8'h3C, 8'h99, 20'hAB53C, 8'h81};
    vecs[6] = '{1'b0, 11'h155, 8'h00, 8'h5A, 20'h15500, 8'h5A};

    repeat (3) @(negedge clk);
    chk("rst_csn", bus4.cs_n, 1);
    chk("rst_sclk", bus4.sclk, 0);
    chk("rst_mosi", bus4.mosi, 0);
    chk("rst_busy", bus4.busy, 0);
    chk("rst_done", bus4.done, 0);
    chk("rst_rd_data", bus4.rd_data, 0);
    chk("rst1_csn", bus1.cs_n, 1);
    chk("rst1_busy", bus1.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run4(vecs[i], -1, -1);

    run4(vecs[5], 3, 50);

    // Reset in the middle of a write frame.
    sdata4 = 8'h00;
    @(negedge clk);
    bus4.wr = 1'b1; bus4.addr = 11'h123; bus4.wdata = 8'h5A; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    for (int k = 2; k <= 80; k++) @(negedge clk);
    chk("pre_rst_busy", bus4.busy, 1);
    chk("pre_rst_sclk", bus4.sclk, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_csn", bus4.cs_n, 1);
    chk("mid_rst_sclk", bus4.sclk, 0);
    chk("mid_rst_busy", bus4.busy, 0);
    chk("mid_rst_mosi", bus4.mosi, 0);
    nd = 0;
    repeat (2) begin @(negedge clk); if (bus4.done) nd++; end
    rst = 1'b0;
    repeat (200) begin @(negedge clk); if (bus4.done) nd++; end
    chk("mid_rst_no_done", nd, 0);
    chk("mid_rst_rd_data", bus4.rd_data, 0);
    chk("mid_rst_csn_idle", bus4.cs_n, 1);
    run4(vecs[6], -1, -1);

    // CLK_DIV=1, start held high for two back-to-back reads.
    sdata1 = 8'h3C;
    @(negedge clk);
    bus1.wr = 1'b0; bus1.addr = 11'h0AA; bus1.wdata = 8'hFF; bus1.start = 1'b1;
    d1 = -1;
    for (int k = 1; k <= 100 && d1 < 0; k++) begin
      @(negedge clk);
      if (bus1.done) d1 = k;
    end
    chk("c1_done_cycle", d1, 42);
    chk("c1_rd_first", bus1.rd_data, 8'h3C);
    chk("c1_busy_at_done", bus1.busy, EXP_BUSY_DONE);
    chk("c1_mosi_frame", rx1, 20'h0AA00);
    sdata1 = 8'hC3;
    gap = 0;
    while (bus1.cs_n && gap < 20) begin gap++; @(negedge clk); end
    bus1.start = 1'b0;
    chk("c1_cs_high", gap, EXP_CS_HIGH);
    m = 0;
    while (!bus1.done && m < 100) begin @(negedge clk); m++; end
    chk("c1_second_done", m, 41);
    chk("c1_rd_second", bus1.rd_data, 8'hC3);
    repeat (5) @(negedge clk);
    chk("c1_idle_after", bus1.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI mode-0 initiator that drives read and write frames into the SPI slave's 8-bit × 2048 register file, one register per frame. It sits on the host/test side of the SPI link. It accepts one command at a time through a start/busy handshake, serialises a 20-bit frame on MOSI, captures MISO during reads, and pulses `done` when chip-select is released.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period; legal range ≥ 1.
- `ADDR_W`, default 11: register address width.
- `DATA_W`, default 8: register data width.
- `clk` input, 1 bit: single system clock; all logic on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: command request; accepted only when `busy` = 0.
- `wr` input, 1 bit: 1 = write, 0 = read; sampled at acceptance.
- `addr` input, `ADDR_W` bits: target register; sampled at acceptance.
- `wdata` input, `DATA_W` bits: write data; sampled at acceptance.
- `busy` output, 1 bit: high from the cycle after acceptance until `done`; in gap builds, until the gap ends.
- `done` output, 1 bit: one-cycle pulse in the cycle `cs_n` returns high.
- `rd_data` output, `DATA_W` bits: last read result; updated at `done` of read frames only.
- `sclk` output, 1 bit: SPI clock; idles low.
- `cs_n` output, 1 bit: chip select, active low.
- `mosi` output, 1 bit: serial data out, MSB first.
- `miso` input, 1 bit: serial data in; sampled on SCLK rising edges.

## Operation
- Frame is 20 bits, MSB first:
  - 1 bit: `wr`.
  - 11 bits: `addr`.
  - 8 bits: for writes, `wdata`; for reads, MOSI is driven 0 and MISO is captured.
- FSM states:
  - IDLE → SETUP when `start` is seen and `busy` = 0. The command is registered into the shift register.
  - SETUP: `cs_n` = 0 and `mosi` = frame bit 19. After `CLK_DIV` cycles, go to SHIFT.
  - SHIFT: SCLK toggles every `CLK_DIV` cycles. On each rising edge, MISO is sampled into the capture register. On each falling edge, the next bit is presented on MOSI. After the 20th falling edge, go to HOLD.
  - HOLD: `sclk` = 0 and `cs_n` = 0 for `CLK_DIV` cycles. Then `cs_n` goes to 1, `done` pulses, `rd_data` loads the 8 captured data-phase bits on reads, and the FSM moves to IDLE (or GAP).
- `start` while `busy` = 1 is ignored, not queued.
- A new `start` is accepted in the same cycle `done` is high (non-gap build only).
- Bit counter is 5 bits and counts 0–19; no wrap beyond 19.
- Address-phase MISO bits are discarded.

## Timing
- Cycle numbering: cycle 0 is the cycle `start` is accepted.
- Cycle 1: `busy` = 1, `cs_n` = 0, first MOSI bit valid.
- SCLK rising edges occur at cycles 1 + CLK_DIV·(2k+1), for k = 0..19.
- Last falling edge is at cycle 1 + 40·CLK_DIV.
- `done` and `cs_n` = 1 occur at cycle 1 + 41·CLK_DIV. For CLK_DIV = 4, that is cycle 165.
- MOSI changes only on falling SCLK or at SETUP, so it is stable ≥ CLK_DIV cycles before each rising edge.
- Reset values: `cs_n` = 1, `sclk` = 0, `mosi` = 0, `busy` = 0, `done` = 0, `rd_data` = 0, FSM = IDLE.
- Reset asserted mid-frame forces reset values immediately, without waiting for a clock. The frame is abandoned, with no `done` and no `rd_data` update.

## Configuration
- `SPI_MASTER_CS_GAP_EN` defined:
  - After HOLD, the FSM enters GAP for `CS_GAP` cycles (`CS_GAP` is a package constant, 4).
  - `cs_n` = 1 and `busy` = 1 during GAP.
  - `start` is ignored during GAP, so back-to-back frames have ≥ 4 + 1 cycles of `cs_n` high.
- `SPI_MASTER_CS_GAP_EN` undefined: GAP state is absent, and `busy` falls in the `done` cycle.

## Structure
- Package `spi_pkg` holds:
  - `ADDR_W`, `DATA_W`.
  - `FRAME_LEN` = 1 + ADDR_W + DATA_W.
  - `CS_GAP`.
  - FSM state enum `spi_m_state_t` (IDLE, SETUP, SHIFT, HOLD, GAP).
- One sub-module, `spi_sclk_gen`: a half-period counter producing a `tick` every `CLK_DIV` cycles while enabled, and toggling `sclk`. It exposes `rise` and `fall` strobes to the FSM.

## Test plan
- Write 0x5A to addr 0x123, CLK_DIV = 4 → MOSI bits on rising edges are 1, 00100100011, 01011010; `done` at cycle 165; `rd_data` stays 0.
- Read addr 0x7FF with a slave model returning 0xA5 → MOSI bits 0, 11111111111, 00000000; `rd_data` = 0xA5 at `done`.
- Assert `start` at cycles 3 and 50 of an active frame → ignored; exactly one `done`; frame bits unchanged.
- Assert `rst` at cycle 80 of a write → same cycle: `cs_n` = 1, `sclk` = 0, `busy` = 0; no `done`; next `start` produces a full correct frame.
- CLK_DIV = 1, two back-to-back reads returning 0x3C then 0xC3:
  - Without the macro, the second frame's `cs_n` falls one cycle after the first `done`.
  - With `SPI_MASTER_CS_GAP_EN`, `cs_n` stays high 5 cycles.
  - `rd_data` sequence is 0x3C, 0xC3.
